// File: rtl/inst_loader_if.sv
// Host/loader/instruction-memory bundle for the program loader.
// Handshake: a word moves on every rising edge where in_valid && in_ready are both high.
// in_ready never depends combinationally on in_valid.
interface inst_loader_if #(
    parameter int D = 10,
    parameter int W = 9
);
    logic         load_req;
    logic [D-1:0] base_addr;
    logic [D-1:0] word_count;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         wr_en;
    logic [D-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         cpu_hold;
    logic         cpu_start;
    logic         load_done;
    logic         err;

    modport master (
        output load_req, base_addr, word_count, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, cpu_start, load_done, err
    );

    modport slave (
        input  load_req, base_addr, word_count, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, cpu_start, load_done, err
    );
endinterface

// File: rtl/inst_loader.sv
// Program loader: streams machine-code words into contiguous instruction memory,
// holding the core in reset until the load completes, then pulses cpu_start.
module inst_loader #(
    parameter int D     = 10,
    parameter int W     = 9,
    parameter int DEPTH = 1024
) (
    input  logic         clk,
    input  logic         reset,
    inst_loader_if.slave bus,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [D:0] DEPTH_L = (D+1)'(DEPTH);

    state_t       state_q, state_d;
    logic [D-1:0] addr_q, addr_d;
    logic [D-1:0] remaining_q, remaining_d;
    logic         in_ready_q, in_ready_d;
    logic         wr_en_q, wr_en_d;
    logic [D-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0] wr_data_q, wr_data_d;
    logic         cpu_hold_q, cpu_hold_d;
    logic         cpu_start_q, cpu_start_d;
    logic         load_done_q, load_done_d;
    logic         err_q, err_d;
    logic [D:0]   end_sum;
    logic         accept;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        cpu_hold_d  = cpu_hold_q;
        cpu_start_d = 1'b0;
        load_done_d = load_done_q;
        err_d       = err_q;
        // One extra bit so base+count reaching exactly DEPTH is still legal.
        end_sum     = {1'b0, bus.base_addr} + {1'b0, bus.word_count};
        accept      = bus.in_valid && in_ready_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.load_req) begin
                    addr_d      = bus.base_addr;
                    remaining_d = bus.word_count;
                    load_done_d = 1'b0;
                    err_d       = 1'b0;
                    cpu_hold_d  = 1'b1;
                    if (end_sum > DEPTH_L) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (bus.word_count == '0) begin
                        state_d = RELEASE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = addr_q;
                    wr_data_d   = bus.in_data;
                    addr_d      = addr_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == D'(1)) state_d = RELEASE;
                end
            end
            RELEASE: begin
                state_d     = DONE;
                cpu_hold_d  = 1'b0;
                cpu_start_d = 1'b1;
                load_done_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            in_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            cpu_hold_q  <= 1'b1;
            cpu_start_q <= 1'b0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            in_ready_q  <= in_ready_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            cpu_hold_q  <= cpu_hold_d;
            cpu_start_q <= cpu_start_d;
            load_done_q <= load_done_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.cpu_start = cpu_start_q;
    assign bus.load_done = load_done_q;
    assign bus.err       = err_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: each scenario task drives a load and checks
// outputs and the logged write / start-pulse timeline against hand-computed values.
module tb_inst_loader;
  localparam int D = 10;
  localparam int W = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] dbg_state;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_cyc = 0;

  inst_loader_if #(.D(D), .W(W)) bus();

  inst_loader #(.D(D), .W(W), .DEPTH(1024)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard logs, captured mid-cycle
  logic [D-1:0] wa_q[$];
  logic [W-1:0] wd_q[$];
  logic [W-1:0] exp_q[$];
  int wc_q[$];
  int ac_q[$];
  int sc_q[$];

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
      wc_q.push_back(cyc);
    end
    if (bus.cpu_start) sc_q.push_back(cyc);
    if (bus.in_valid && bus.in_ready) ac_q.push_back(cyc);
    if (bus.load_req) req_cyc = cyc;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    ac_q.delete(); sc_q.delete(); exp_q.delete();
  endtask

  task automatic start_load(input logic [D-1:0] b, input logic [D-1:0] c);
    bus.load_req = 1'b1;
    bus.base_addr = b;
    bus.word_count = c;
    step();
    bus.load_req = 1'b0;
  endtask

  // Offers exp_q words in order; vpat bit t gives in_valid at step t (then 1).
  task automatic feed(input logic [15:0] vpat, output bit timeout);
    int idx = 0;
    int t = 0;
    bit acc;
    while (idx < exp_q.size() && t < 200) begin
      bus.in_valid = (t < 16) ? vpat[t] : 1'b1;
      bus.in_data = exp_q[idx];
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) idx++;
      t++;
    end
    bus.in_valid = 1'b0;
    timeout = (idx < exp_q.size());
  endtask

  // Compares write log against base..base+n-1 / exp_q, and write-after-accept timing.
  task automatic check_writes(input string name, input logic [D-1:0] base);
    checks++;
    if (wa_q.size() !== exp_q.size()) begin
      failures++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wa_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (wa_q[i] !== base + D'(i) || wd_q[i] !== exp_q[i] || wc_q[i] !== ac_q[i] + 1) begin
          failures++;
          $display("FAIL %s write%0d: got addr %0d data %h cyc %0d expected addr %0d data %h cyc %0d",
                   name, i, wa_q[i], wd_q[i], wc_q[i], base + D'(i), exp_q[i], ac_q[i] + 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    checks++;
    if ({bus.cpu_hold, bus.in_ready, bus.wr_en, bus.cpu_start, bus.load_done, bus.err} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected %b",
               {bus.cpu_hold, bus.in_ready, bus.wr_en, bus.cpu_start, bus.load_done, bus.err}, 6'b100000);
    end
    checks++;
    if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    clear_logs();
    repeat (10) step();
    checks++;
    if (wa_q.size() !== 0 || bus.cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL reset_idle: got writes %0d hold %b expected writes 0 hold 1", wa_q.size(), bus.cpu_hold);
    end
  endtask

  task automatic test_basic_load();
    bit to;
    clear_logs();
    exp_q.push_back(9'h1FF); exp_q.push_back(9'h0A5); exp_q.push_back(9'h100);
    start_load(10'd0, 10'd3);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL basic_ready: got ready %b hold %b expected 1 1", bus.in_ready, bus.cpu_hold);
    end
    feed(16'hFFFF, to);
    checks++;
    if (to) begin failures++; $display("FAIL basic_timeout: got timeout 1 expected 0"); end
    checks++;
    if (bus.in_ready !== 1'b0 || bus.cpu_start !== 1'b0 || bus.cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL basic_release: got ready %b start %b hold %b expected 0 0 1",
               bus.in_ready, bus.cpu_start, bus.cpu_hold);
    end
    step();
    checks++;
    if (bus.cpu_start !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.load_done !== 1'b1) begin
      failures++;
      $display("FAIL basic_done: got start %b hold %b done %b expected 1 0 1",
               bus.cpu_start, bus.cpu_hold, bus.load_done);
    end
    step(); step();
    check_writes("basic", 10'd0);
    checks++;
    if (sc_q.size() !== 1 || ac_q.size() !== 3 || sc_q[0] !== ac_q[2] + 2) begin
      failures++;
      $display("FAIL basic_start_pulse: got %0d pulses first at %0d expected 1 pulse at %0d",
               sc_q.size(), (sc_q.size() > 0) ? sc_q[0] : -1, (ac_q.size() > 2) ? ac_q[2] + 2 : -1);
    end
  endtask

  task automatic test_gapped_load();
    bit to;
    clear_logs();
    exp_q.push_back(9'h012); exp_q.push_back(9'h034); exp_q.push_back(9'h056); exp_q.push_back(9'h078);
    start_load(10'd10, 10'd4);
    feed(16'h0059, to);
    checks++;
    if (to) begin failures++; $display("FAIL gapped_timeout: got timeout 1 expected 0"); end
    repeat (3) step();
    check_writes("gapped", 10'd10);
    checks++;
    if (bus.load_done !== 1'b1 || sc_q.size() !== 1) begin
      failures++;
      $display("FAIL gapped_done: got done %b pulses %0d expected 1 1", bus.load_done, sc_q.size());
    end
  endtask

  task automatic test_range();
    bit to;
    clear_logs();
    start_load(10'd1020, 10'd5);
    checks++;
    if (bus.err !== 1'b1 || bus.in_ready !== 1'b0 || bus.cpu_hold !== 1'b1 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL range_reject: got err %b ready %b hold %b state %0d expected 1 0 1 0",
               bus.err, bus.in_ready, bus.cpu_hold, dbg_state);
    end
    bus.in_valid = 1'b1;
    repeat (4) step();
    bus.in_valid = 1'b0;
    checks++;
    if (wa_q.size() !== 0 || bus.err !== 1'b1) begin
      failures++;
      $display("FAIL range_no_write: got writes %0d err %b expected 0 1", wa_q.size(), bus.err);
    end
    clear_logs();
    exp_q.push_back(9'h011); exp_q.push_back(9'h022); exp_q.push_back(9'h033); exp_q.push_back(9'h044);
    start_load(10'd1020, 10'd4);
    checks++;
    if (bus.err !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL range_edge_accept: got err %b ready %b expected 0 1", bus.err, bus.in_ready);
    end
    feed(16'hFFFF, to);
    step(); step();
    check_writes("range_edge", 10'd1020);
    checks++;
    if (bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL range_edge_done: got done %b hold %b expected 1 0", bus.load_done, bus.cpu_hold);
    end
  endtask

  task automatic test_zero_count();
    clear_logs();
    start_load(10'd7, 10'd0);
    checks++;
    if (bus.load_done !== 1'b0 || bus.in_ready !== 1'b0 || bus.cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL zero_after_req: got done %b ready %b hold %b expected 0 0 1",
               bus.load_done, bus.in_ready, bus.cpu_hold);
    end
    step(); step(); step();
    checks++;
    if (wa_q.size() !== 0 || sc_q.size() !== 1 || sc_q[0] !== req_cyc + 2 || bus.load_done !== 1'b1) begin
      failures++;
      $display("FAIL zero_start: got writes %0d pulses %0d at %0d done %b expected 0 1 at %0d done 1",
               wa_q.size(), sc_q.size(), (sc_q.size() > 0) ? sc_q[0] : -1, bus.load_done, req_cyc + 2);
    end
    start_load(10'd20, 10'd0);
    checks++;
    if (bus.cpu_hold !== 1'b1 || bus.load_done !== 1'b0) begin
      failures++;
      $display("FAIL reload_from_done: got hold %b done %b expected 1 0", bus.cpu_hold, bus.load_done);
    end
    step(); step();
    checks++;
    if (bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b0) begin
      failures++;
      $display("FAIL reload_complete: got done %b hold %b expected 1 0", bus.load_done, bus.cpu_hold);
    end
  endtask

  task automatic test_reset_mid_load();
    bit to;
    clear_logs();
    start_load(10'd0, 10'd5);
    bus.in_valid = 1'b1;
    bus.in_data = 9'h0AA;
    step();
    bus.in_data = 9'h0BB;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.in_valid = 1'b0;
    checks++;
    if ({bus.cpu_hold, bus.in_ready, bus.wr_en, bus.cpu_start, bus.load_done, bus.err} !== 6'b100000) begin
      failures++;
      $display("FAIL midreset_outputs: got %b expected %b",
               {bus.cpu_hold, bus.in_ready, bus.wr_en, bus.cpu_start, bus.load_done, bus.err}, 6'b100000);
    end
    repeat (5) step();
    checks++;
    if (wa_q.size() !== 2 || sc_q.size() !== 0) begin
      failures++;
      $display("FAIL midreset_writes: got writes %0d pulses %0d expected 2 0", wa_q.size(), sc_q.size());
    end
    clear_logs();
    exp_q.push_back(9'h155);
    start_load(10'd0, 10'd1);
    feed(16'hFFFF, to);
    step(); step();
    check_writes("after_reset", 10'd0);
    checks++;
    if (bus.load_done !== 1'b1 || sc_q.size() !== 1) begin
      failures++;
      $display("FAIL after_reset_done: got done %b pulses %0d expected 1 1", bus.load_done, sc_q.size());
    end
  endtask

  initial begin
    bus.load_req = 1'b0;
    bus.base_addr = '0;
    bus.word_count = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    test_reset();
    test_basic_load();
    test_gapped_load();
    test_range();
    test_zero_count();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
